dbg_cmd_sysclk_bridge: RTL and testbench

- System-clock half of the CPU debug slave, replacing the fixed 2-bit-IR / 38-bit debug command decoder.
- Receives the JTAG-domain shift register (sr), IR and update strobes as asynchronous inputs, and synchronises the strobes into clk.
- Captures each update-DR as a command into a parametrised FIFO and presents it to the OCI logic over a valid/ready handshake.
- Behaviour the old block lacks: back-pressure, buffering, overflow reporting, and arbitrary IR/data widths.

---
 rtl/dbg_cmd_sysclk_bridge.sv | 138 +++++++++++++
 tb/tb_dbg_cmd_sysclk_bridge.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dbg_cmd_sysclk_bridge.sv
// System-clock half of the CPU debug slave: synchronises JTAG update strobes and queues each update-DR as a command.
// Optional: define DBG_CMD_PARITY_EN to drop odd-parity commands and flag them on parity_err.
module dbg_cmd_sysclk_bridge #(
    parameter int SR_WIDTH    = 38,
    parameter int IR_WIDTH    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [IR_WIDTH-1:0]           ir_in,
    input  logic [SR_WIDTH-1:0]           sr,
    input  logic                          vs_udr,
    input  logic                          vs_uir,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [IR_WIDTH-1:0]           cmd_ir,
    output logic [SR_WIDTH-1:0]           jdo,
    output logic                          cmd_take_action,
    output logic                          ir_update,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          parity_err,
    input  logic                          clr_status
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int AW = CW - 1;
    localparam int DW = IR_WIDTH + SR_WIDTH;

    logic [SYNC_STAGES-1:0] udr_sync_reg;
    logic [SYNC_STAGES-1:0] uir_sync_reg;
    logic                   udr_last_reg;
    logic                   uir_last_reg;
    logic                   udr_rise;
    logic                   uir_rise;
    logic                   ir_update_reg;
    logic                   cap_valid_reg;
    logic [DW-1:0]          cap_data_reg;
    logic [CW-1:0]          wr_ptr_reg;
    logic [CW-1:0]          rd_ptr_reg;
    logic [DW-1:0]          mem [FIFO_DEPTH];
    logic [DW-1:0]          head;
    logic [CW-1:0]          count;
    logic                   full;
    logic                   pop;
    logic                   push_req;
    logic                   push;
    logic                   drop;
    logic                   parity_bad;
    logic                   overflow_reg;

    // Only the last synchroniser stage is compared, so a held level gives a single strobe.
    assign udr_rise = udr_sync_reg[SYNC_STAGES-1] & ~udr_last_reg;
    assign uir_rise = uir_sync_reg[SYNC_STAGES-1] & ~uir_last_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_sync_reg  <= '0;
            uir_sync_reg  <= '0;
            udr_last_reg  <= 1'b0;
            uir_last_reg  <= 1'b0;
            ir_update_reg <= 1'b0;
            cap_valid_reg <= 1'b0;
            cap_data_reg  <= '0;
        end else begin
            udr_sync_reg  <= {udr_sync_reg[SYNC_STAGES-2:0], vs_udr};
            uir_sync_reg  <= {uir_sync_reg[SYNC_STAGES-2:0], vs_uir};
            udr_last_reg  <= udr_sync_reg[SYNC_STAGES-1];
            uir_last_reg  <= uir_sync_reg[SYNC_STAGES-1];
            ir_update_reg <= uir_rise;
            cap_valid_reg <= udr_rise;
            if (udr_rise) begin
                cap_data_reg <= {ir_in, sr};
            end
        end
    end

`ifdef DBG_CMD_PARITY_EN
    logic parity_err_reg;

    assign parity_bad = ^cap_data_reg[SR_WIDTH-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_err_reg <= 1'b0;
        end else begin
            parity_err_reg <= (cap_valid_reg & parity_bad) | (parity_err_reg & ~clr_status);
        end
    end

    assign parity_err = parity_err_reg;
`else
    assign parity_bad = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign count    = wr_ptr_reg - rd_ptr_reg;
    assign full     = (count == CW'(FIFO_DEPTH));
    assign pop      = cmd_valid & cmd_ready;
    assign push_req = cap_valid_reg & ~parity_bad;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            overflow_reg <= drop | (overflow_reg & ~clr_status);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= cap_data_reg;
        end
    end

    // Storage is not reset, so the head is masked until an entry is present.
    assign head            = mem[rd_ptr_reg[AW-1:0]];
    assign cmd_valid       = (count != '0);
    assign jdo             = cmd_valid ? head[SR_WIDTH-1:0] : '0;
    assign cmd_ir          = cmd_valid ? head[DW-1:SR_WIDTH] : '0;
    assign cmd_take_action = jdo[SR_WIDTH-1];
    assign ir_update       = ir_update_reg;
    assign fifo_count      = count;
    assign overflow        = overflow_reg;

endmodule

// File: tb/tb_dbg_cmd_sysclk_bridge.sv
// Directed bench for dbg_cmd_sysclk_bridge: table-driven FIFO fill/drain plus latency and reset sequences.
module tb_dbg_cmd_sysclk_bridge;

    localparam int SRW = 38;
    localparam int IRW = 2;
    localparam int SS  = 2;
    localparam int FD  = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [IRW-1:0]  ir_in;
    logic [SRW-1:0]  sr;
    logic            vs_udr;
    logic            vs_uir;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [IRW-1:0]  cmd_ir;
    logic [SRW-1:0]  jdo;
    logic            cmd_take_action;
    logic            ir_update;
    logic [2:0]      fifo_count;
    logic            overflow;
    logic            parity_err;
    logic            clr_status;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [IRW-1:0] ir;
        logic [SRW-1:0] data;
        logic           take;
    } vec_t;

    vec_t vecs [6];

    dbg_cmd_sysclk_bridge #(
        .SR_WIDTH(SRW), .IR_WIDTH(IRW), .SYNC_STAGES(SS), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
        .vs_udr(vs_udr), .vs_uir(vs_uir), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .jdo(jdo),
        .cmd_take_action(cmd_take_action), .ir_update(ir_update),
        .fifo_count(fifo_count), .overflow(overflow),
        .parity_err(parity_err), .clr_status(clr_status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_udr(input logic [IRW-1:0] ir_v, input logic [SRW-1:0] sr_v);
        ir_in  = ir_v;
        sr     = sr_v;
        vs_udr = 1'b1;
        repeat (SS + 2) tick();
        vs_udr = 1'b0;
        repeat (SS + 1) tick();
    endtask

    task automatic check_head(input string name, input int i);
        chk({name, "_valid"}, 64'(cmd_valid), 64'(1));
        chk({name, "_jdo"}, 64'(jdo), 64'(vecs[i].data));
        chk({name, "_ir"}, 64'(cmd_ir), 64'(vecs[i].ir));
        chk({name, "_take"}, 64'(cmd_take_action), 64'(vecs[i].take));
    endtask

    task automatic pop_one();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{2'b01, 38'h20_0000_0001, 1'b1};
        vecs[1] = '{2'b10, 38'h0F_0F0F_0F0F, 1'b0};
        vecs[2] = '{2'b11, 38'h3F_FFFF_FFFF, 1'b1};
        vecs[3] = '{2'b00, 38'h00_0000_00C0, 1'b0};
        vecs[4] = '{2'b01, 38'h11_1111_1111, 1'b0};
        vecs[5] = '{2'b10, 38'h33_3333_3333, 1'b1};

        reset_n = 1'b0; ir_in = '0; sr = '0; vs_udr = 1'b0; vs_uir = 1'b0;
        cmd_ready = 1'b0; clr_status = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 64'(cmd_valid), 64'(0));
        chk("rst_jdo", 64'(jdo), 64'(0));
        chk("rst_count", 64'(fifo_count), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        chk("rst_irupd", 64'(ir_update), 64'(0));
        chk("rst_perr", 64'(parity_err), 64'(0));
        reset_n = 1'b1;
        tick();

        // Single command latency: valid appears SS+2 edges after vs_udr
        ir_in = 2'b10; sr = 38'h2_0000_0001; vs_udr = 1'b1;
        repeat (SS + 1) tick();
        chk("lat_early_valid", 64'(cmd_valid), 64'(0));
        tick();
        chk("lat_valid", 64'(cmd_valid), 64'(1));
        vs_udr = 1'b0;
        chk("lat_jdo", 64'(jdo), 64'(38'h2_0000_0001));
        chk("lat_ir", 64'(cmd_ir), 64'(2'b10));
        chk("lat_take", 64'(cmd_take_action), 64'(0));
        chk("lat_count", 64'(fifo_count), 64'(1));
        ir_in = 2'b01; sr = 38'h3F_0000_0000;
        repeat (5) tick();
        chk("hold_valid", 64'(cmd_valid), 64'(1));
        chk("hold_jdo", 64'(jdo), 64'(38'h2_0000_0001));
        pop_one();
        chk("pop_valid", 64'(cmd_valid), 64'(0));
        chk("pop_count", 64'(fifo_count), 64'(0));

        // Overflow: five updates into a four-deep FIFO
        for (int i = 0; i < 5; i++) begin
            pulse_udr(vecs[i].ir, vecs[i].data);
            if (i == 3) chk("full_noovf", 64'(overflow), 64'(0));
        end
        chk("ovf_count", 64'(fifo_count), 64'(4));
        chk("ovf_flag", 64'(overflow), 64'(1));
        for (int i = 0; i < 4; i++) begin
            check_head($sformatf("drain%0d", i), i);
            pop_one();
        end
        chk("drain_empty", 64'(cmd_valid), 64'(0));
        chk("ovf_sticky", 64'(overflow), 64'(1));
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("ovf_clr", 64'(overflow), 64'(0));

        // Full FIFO, pop coincident with push
        for (int i = 0; i < 4; i++) pulse_udr(vecs[i].ir, vecs[i].data);
        ir_in = vecs[5].ir; sr = vecs[5].data; vs_udr = 1'b1;
        repeat (SS + 1) tick();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        vs_udr = 1'b0;
        repeat (SS + 1) tick();
        chk("pp_count", 64'(fifo_count), 64'(4));
        chk("pp_ovf", 64'(overflow), 64'(0));
        for (int i = 1; i < 4; i++) begin
            check_head($sformatf("pp_drain%0d", i), i);
            pop_one();
        end
        check_head("pp_last", 5);
        pop_one();
        chk("pp_empty", 64'(fifo_count), 64'(0));

        // Update-IR strobe timing
        vs_uir = 1'b1;
        repeat (SS) tick();
        chk("uir_early", 64'(ir_update), 64'(0));
        tick();
        chk("uir_pulse", 64'(ir_update), 64'(1));
        tick();
        chk("uir_single", 64'(ir_update), 64'(0));
        vs_uir = 1'b0;
        chk("uir_count", 64'(fifo_count), 64'(0));

        // Long update-DR level gives one command
        ir_in = vecs[2].ir; sr = vecs[2].data; vs_udr = 1'b1;
        repeat (20) tick();
        vs_udr = 1'b0;
        repeat (6) tick();
        chk("long_count", 64'(fifo_count), 64'(1));
        check_head("long_head", 2);
        pop_one();

        // Asynchronous reset with three entries queued
        for (int i = 0; i < 3; i++) pulse_udr(vecs[i].ir, vecs[i].data);
        chk("pre_rst_count", 64'(fifo_count), 64'(3));
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 64'(cmd_valid), 64'(0));
        chk("arst_count", 64'(fifo_count), 64'(0));
        chk("arst_jdo", 64'(jdo), 64'(0));
        chk("arst_ir", 64'(cmd_ir), 64'(0));
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        chk("post_rst_valid", 64'(cmd_valid), 64'(0));

`ifdef DBG_CMD_PARITY_EN
        pulse_udr(2'b00, 38'h1);
        chk("par_err", 64'(parity_err), 64'(1));
        chk("par_count", 64'(fifo_count), 64'(0));
        pulse_udr(2'b00, 38'h3);
        chk("par_ok_count", 64'(fifo_count), 64'(1));
        chk("par_ok_jdo", 64'(jdo), 64'(38'h3));
`else
        pulse_udr(2'b00, 38'h1);
        chk("nopar_err", 64'(parity_err), 64'(0));
        chk("nopar_count", 64'(fifo_count), 64'(1));
        chk("nopar_jdo", 64'(jdo), 64'(38'h1));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
